upg_boot_ctrl: RTL and testbench

- Parametrised programming-mode controller between the UART programmer core and the CPU/memories.
- Debounces the start button and sequences RUN / PROG / HOLD modes.
- Generates the UART-programmer reset and a stretched CPU reset.
- Demultiplexes UART write beats into 2^BANK_SEL_W memory banks by address MSBs; the previous design had a fixed 2-way split.

---
 rtl/upg_boot_ctrl_pkg.sv | 22 ++
 rtl/upg_boot_ctrl_if.sv | 30 +++
 rtl/upg_boot_ctrl_btn_debounce.sv | 44 ++++
 rtl/upg_boot_ctrl.sv | 119 +++++++++++
 tb/tb_upg_boot_ctrl.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/upg_boot_ctrl_pkg.sv
// Shared encodings and defaults for the programming-mode boot controller.
// The state encoding doubles as the mode_o value, so the state register drives mode_o directly.
package upg_pkg;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_PROG = 2'b01;
  localparam logic [1:0] MODE_HOLD = 2'b10;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 200000;
  localparam int DEFAULT_RST_HOLD_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_RUN  = MODE_RUN,
    ST_PROG = MODE_PROG,
    ST_HOLD = MODE_HOLD
  } upg_state_e;

  function automatic int upg_nbank(input int bank_sel_w);
    return 1 << bank_sel_w;
  endfunction

endpackage

// File: rtl/upg_boot_ctrl_if.sv
// Write bus between the UART programmer and the memory banks, routed through the boot controller.
interface upg_boot_ctrl_if #(
  parameter int ADDR_W     = 15,
  parameter int BANK_SEL_W = 1,
  parameter int DATA_W     = 32
);
  import upg_pkg::*;
  localparam int NBANK = upg_nbank(BANK_SEL_W);

  // A write beat is upg_wen_i high at a clock edge; there is no back-pressure, so every
  // beat seen in PROG is taken and appears on the bank side exactly one cycle later.
  logic                         upg_wen_i;
  logic [ADDR_W-1:0]            upg_addr_i;
  logic [DATA_W-1:0]            upg_data_i;
  logic                         upg_done_i;
  logic [NBANK-1:0]             bank_wen_o;
  logic [ADDR_W-BANK_SEL_W-1:0] bank_addr_o;
  logic [DATA_W-1:0]            bank_data_o;

  modport master (
    input  upg_wen_i, upg_addr_i, upg_data_i, upg_done_i,
    output bank_wen_o, bank_addr_o, bank_data_o
  );

  modport slave (
    output upg_wen_i, upg_addr_i, upg_data_i, upg_done_i,
    input  bank_wen_o, bank_addr_o, bank_data_o
  );

endinterface

// File: rtl/upg_boot_ctrl_btn_debounce.sv
// Start-button conditioner: 2-flop synchroniser, stable-high counter, one pulse per press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 200000
) (
  input  logic fpga_clk,
  input  logic fpga_rst,
  input  logic start_btn,
  output logic start_pulse
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  logic             sync_q1;
  logic             sync_q2;
  logic [CNT_W-1:0] cnt;
  logic             level;
  logic             hit;

  assign hit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      cnt         <= '0;
      level       <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      sync_q1     <= start_btn;
      sync_q2     <= sync_q1;
      start_pulse <= 1'b0;
      if (!sync_q2) begin
        cnt   <= '0;
        level <= 1'b0;
      end else if (hit) begin
        // Counter parks here while held; the pulse fires only on the level's first rise.
        level       <= 1'b1;
        start_pulse <= !level;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/upg_boot_ctrl.sv
// Programming-mode controller: RUN/PROG/HOLD sequencing, UART/CPU resets and bank write demux.
module upg_boot_ctrl
  import upg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int RST_HOLD_CYCLES = DEFAULT_RST_HOLD_CYCLES,
  parameter int ADDR_W          = 15,
  parameter int BANK_SEL_W      = 1,
  parameter int DATA_W          = 32
) (
  input  logic                   fpga_clk,
  input  logic                   fpga_rst,
  input  logic                   start_btn,
  upg_boot_ctrl_if.master        bus,
  output logic                   upg_rst_o,
  output logic                   cpu_rst_o,
  output logic [1:0]             mode_o,
  output logic [ADDR_W:0]        word_cnt_o
);
  localparam int NBANK  = upg_nbank(BANK_SEL_W);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int HOLD_W = $clog2(RST_HOLD_CYCLES) + 1;
  localparam int LOW_W  = ADDR_W - BANK_SEL_W;

  upg_state_e           state, state_n;
  logic [HOLD_W-1:0]    hold_cnt, hold_cnt_n;
  logic [CNT_W-1:0]     word_cnt_n;
  logic                 upg_rst_n, cpu_rst_n;
  logic                 upg_done_q;
  logic                 done_rise;
  logic                 start_pulse;
  logic                 beat_ok;
  logic [BANK_SEL_W-1:0] bank_sel;
  logic [NBANK-1:0]     bank_wen_n;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .fpga_clk   (fpga_clk),
    .fpga_rst   (fpga_rst),
    .start_btn  (start_btn),
    .start_pulse(start_pulse)
  );

  assign done_rise = bus.upg_done_i & ~upg_done_q;
  assign bank_sel  = bus.upg_addr_i[ADDR_W-1 -: BANK_SEL_W];
  assign mode_o    = state;

  always_comb begin
    state_n    = state;
    hold_cnt_n = hold_cnt;
    word_cnt_n = word_cnt_o;
    beat_ok    = 1'b0;
    upg_rst_n  = 1'b1;
    case (state)
      ST_HOLD: begin
        if (hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
          state_n    = ST_RUN;
          hold_cnt_n = '0;
        end else begin
          hold_cnt_n = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (start_pulse) begin
          state_n    = ST_PROG;
          word_cnt_n = '0;
        end
      end
      ST_PROG: begin
        if (start_pulse) begin
          // Restart wins over done; the beat in this cycle belongs to the old session.
          word_cnt_n = '0;
        end else begin
          beat_ok = bus.upg_wen_i;
          if (beat_ok && (word_cnt_o != '1)) word_cnt_n = word_cnt_o + CNT_W'(1);
          if (done_rise) begin
            state_n    = ST_HOLD;
            hold_cnt_n = '0;
          end
        end
      end
      default: begin
        state_n    = ST_HOLD;
        hold_cnt_n = '0;
      end
    endcase
    if (state_n == ST_PROG && !(state == ST_PROG && start_pulse)) upg_rst_n = 1'b0;
    cpu_rst_n  = (state_n != ST_RUN);
    bank_wen_n = beat_ok ? (NBANK'(1) << bank_sel) : '0;
  end

  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      state           <= ST_HOLD;
      hold_cnt        <= '0;
      word_cnt_o      <= '0;
      upg_rst_o       <= 1'b1;
      cpu_rst_o       <= 1'b1;
      upg_done_q      <= 1'b0;
      bus.bank_wen_o  <= '0;
      bus.bank_addr_o <= '0;
      bus.bank_data_o <= '0;
    end else begin
      state          <= state_n;
      hold_cnt       <= hold_cnt_n;
      word_cnt_o     <= word_cnt_n;
      upg_rst_o      <= upg_rst_n;
      cpu_rst_o      <= cpu_rst_n;
      upg_done_q     <= bus.upg_done_i;
      bus.bank_wen_o <= bank_wen_n;
      if (beat_ok) begin
        bus.bank_addr_o <= bus.upg_addr_i[LOW_W-1:0];
        bus.bank_data_o <= bus.upg_data_i;
      end
    end
  end

endmodule

// File: tb/tb_upg_boot_ctrl.sv
// Directed bench for upg_boot_ctrl with short debounce/hold settings and a 4-bank split.
module tb_upg_boot_ctrl;
  localparam int DEB    = 4;
  localparam int HOLD   = 3;
  localparam int ADDR_W = 15;
  localparam int BSW    = 2;
  localparam int DATA_W = 32;

  logic              fpga_clk;
  logic              fpga_rst;
  logic              start_btn;
  logic              upg_rst_o;
  logic              cpu_rst_o;
  logic [1:0]        mode_o;
  logic [ADDR_W:0]   word_cnt_o;

  int n_checks;
  int n_errors;

  upg_boot_ctrl_if #(.ADDR_W(ADDR_W), .BANK_SEL_W(BSW), .DATA_W(DATA_W)) bus ();

  upg_boot_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RST_HOLD_CYCLES(HOLD),
    .ADDR_W         (ADDR_W),
    .BANK_SEL_W     (BSW),
    .DATA_W         (DATA_W)
  ) dut (
    .fpga_clk  (fpga_clk),
    .fpga_rst  (fpga_rst),
    .start_btn (start_btn),
    .bus       (bus.master),
    .upg_rst_o (upg_rst_o),
    .cpu_rst_o (cpu_rst_o),
    .mode_o    (mode_o),
    .word_cnt_o(word_cnt_o)
  );

  // clock / reset
  initial fpga_clk = 1'b0;
  always #5 fpga_clk = ~fpga_clk;

  // driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge fpga_clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_beat(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    bus.upg_wen_i  = 1'b1;
    bus.upg_addr_i = addr;
    bus.upg_data_i = data;
    tick();
    bus.upg_wen_i  = 1'b0;
  endtask

  task automatic check_hold_then_run(input string tag);
    for (int i = 0; i < HOLD; i++) begin
      check({tag, "_hold_mode"}, 64'(mode_o), 64'h2);
      check({tag, "_hold_cpu"}, 64'(cpu_rst_o), 64'h1);
      tick();
    end
    check({tag, "_run_mode"}, 64'(mode_o), 64'h0);
    check({tag, "_run_cpu"}, 64'(cpu_rst_o), 64'h0);
    check({tag, "_run_upg"}, 64'(upg_rst_o), 64'h1);
  endtask

  initial begin
    int entries;
    int restarts;
    logic [1:0] prev_mode;

    n_checks       = 0;
    n_errors       = 0;
    fpga_rst       = 1'b1;
    start_btn      = 1'b0;
    bus.upg_wen_i  = 1'b0;
    bus.upg_addr_i = '0;
    bus.upg_data_i = '0;
    bus.upg_done_i = 1'b0;
    tick(3);

    check("rst_mode", 64'(mode_o), 64'h2);
    check("rst_upg", 64'(upg_rst_o), 64'h1);
    check("rst_cpu", 64'(cpu_rst_o), 64'h1);
    check("rst_wen", 64'(bus.bank_wen_o), 64'h0);
    check("rst_addr", 64'(bus.bank_addr_o), 64'h0);
    check("rst_data", 64'(bus.bank_data_o), 64'h0);
    check("rst_cnt", 64'(word_cnt_o), 64'h0);
    fpga_rst = 1'b0;
    check_hold_then_run("boot");

    // Two 3-cycle presses never reach the 4-cycle threshold.
    start_btn = 1'b1; tick(3);
    start_btn = 1'b0; tick();
    start_btn = 1'b1; tick(3);
    start_btn = 1'b0; tick(6);
    check("glitch_mode", 64'(mode_o), 64'h0);

    // A long hold gives one entry and no restart pulses.
    entries   = 0;
    restarts  = 0;
    prev_mode = mode_o;
    start_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prev_mode == 2'b00 && mode_o == 2'b01) entries++;
      if (mode_o == 2'b01 && upg_rst_o) restarts++;
      prev_mode = mode_o;
    end
    start_btn = 1'b0;
    check("hold_entries", 64'(entries), 64'd1);
    check("hold_restarts", 64'(restarts), 64'd0);
    tick(4);
    check("prog_mode", 64'(mode_o), 64'h1);
    check("prog_upg", 64'(upg_rst_o), 64'h0);
    check("prog_cpu", 64'(cpu_rst_o), 64'h1);
    check("prog_cnt0", 64'(word_cnt_o), 64'h0);

    // Bank demux on the two top address bits.
    write_beat(15'h4005, 32'hDEADBEEF);
    check("dmx1_wen", 64'(bus.bank_wen_o), 64'h4);
    check("dmx1_addr", 64'(bus.bank_addr_o), 64'h0005);
    check("dmx1_data", 64'(bus.bank_data_o), 64'hDEADBEEF);
    check("dmx1_cnt", 64'(word_cnt_o), 64'h1);
    tick();
    check("dmx1_wen_drop", 64'(bus.bank_wen_o), 64'h0);
    write_beat(15'h7FFF, 32'h12345678);
    check("dmx2_wen", 64'(bus.bank_wen_o), 64'h8);
    check("dmx2_addr", 64'(bus.bank_addr_o), 64'h1FFF);
    check("dmx2_cnt", 64'(word_cnt_o), 64'h2);

    // Done rising together with a write: the beat still lands.
    bus.upg_done_i = 1'b1;
    write_beat(15'h0003, 32'hA5A5A5A5);
    check("done_wen", 64'(bus.bank_wen_o), 64'h1);
    check("done_addr", 64'(bus.bank_addr_o), 64'h0003);
    check("done_cnt", 64'(word_cnt_o), 64'h3);
    check_hold_then_run("done");
    write_beat(15'h2001, 32'h0BADF00D);
    check("run_wen", 64'(bus.bank_wen_o), 64'h0);
    check("run_addr_hold", 64'(bus.bank_addr_o), 64'h0003);
    check("run_data_hold", 64'(bus.bank_data_o), 64'hA5A5A5A5);
    check("run_cnt_hold", 64'(word_cnt_o), 64'h3);
    bus.upg_done_i = 1'b0;

    // Re-enter PROG and log five beats.
    start_btn = 1'b1; tick(10);
    start_btn = 1'b0; tick(4);
    check("reenter_mode", 64'(mode_o), 64'h1);
    check("reenter_cnt", 64'(word_cnt_o), 64'h0);
    for (int i = 0; i < 5; i++) write_beat(15'(i), 32'(i + 100));
    tick();
    check("five_cnt", 64'(word_cnt_o), 64'h5);

    // Button pulse reaches the FSM at the 7th edge; done rises on that same edge.
    start_btn = 1'b1;
    tick(6);
    check("pre_restart_upg", 64'(upg_rst_o), 64'h0);
    bus.upg_done_i = 1'b1;
    tick();
    check("restart_upg", 64'(upg_rst_o), 64'h1);
    check("restart_mode", 64'(mode_o), 64'h1);
    check("restart_cnt", 64'(word_cnt_o), 64'h0);
    tick();
    check("restart_upg_drop", 64'(upg_rst_o), 64'h0);
    check("restart_mode2", 64'(mode_o), 64'h1);
    start_btn      = 1'b0;
    bus.upg_done_i = 1'b0;
    tick(4);
    write_beat(15'h0010, 32'h00000001);
    check("post_restart_cnt", 64'(word_cnt_o), 64'h1);

    // Reset lands on a write beat.
    fpga_rst = 1'b1;
    write_beat(15'h4005, 32'hCAFEF00D);
    check("midrst_wen", 64'(bus.bank_wen_o), 64'h0);
    check("midrst_cnt", 64'(word_cnt_o), 64'h0);
    check("midrst_upg", 64'(upg_rst_o), 64'h1);
    fpga_rst = 1'b0;
    check_hold_then_run("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
